// File: rtl/mipsfpga_ahb_sevensegscan_if.sv
// Register-slave side of the seven-segment scan driver: shadow inputs, load
// strobe, live brightness, and the scanned display pins.
interface mipsfpga_ahb_sevensegscan_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   en_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blink_in;
  logic [3:0]              brightness;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic                    frame_start;
  logic                    pending;

  modport master (
    output load, digits_in, en_in, dp_in, blink_in, brightness,
    input  an_n, seg_n, dp_n, frame_start, pending
  );

  modport slave (
    input  load, digits_in, en_in, dp_in, blink_in, brightness,
    output an_n, seg_n, dp_n, frame_start, pending
  );
endinterface

// File: rtl/mipsfpga_ahb_sevensegscan.sv
// Multiplexed seven-segment scan driver with per-digit dp/blink, 16-level PWM
// brightness and frame-synchronous double-buffered digit updates.
module mipsfpga_ahb_sevensegscan #(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 12500,
  parameter int BLINK_FRAMES = 64
) (
  input logic                   clk,
  input logic                   reset,
  mipsfpga_ahb_sevensegscan_if.slave bus
);
  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int SEL_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int WIN    = SLOT_CYCLES / 16;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  logic [SLOT_W-1:0]       slot_cnt;
  logic [SEL_W-1:0]        sel;
  logic [FRM_W-1:0]        frame_cnt;
  logic                    blink_phase;
  logic [3:0]              bright_q;
  logic                    pending_q;

  logic [4*NUM_DIGITS-1:0] pend_digit, active_digit;
  logic [NUM_DIGITS-1:0]   pend_en, active_en;
  logic [NUM_DIGITS-1:0]   pend_dp, active_dp;
  logic [NUM_DIGITS-1:0]   pend_blink, active_blink;

  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic                    frame_q;

  logic                    slot_wrap, boundary;
  logic                    cur_en, cur_dp, cur_blink;
  logic [3:0]              cur_digit;
  logic [SLOT_W-1:0]       w_idx;
  logic                    pwm_on, lit;

  function automatic logic [6:0] hexdec(input logic [3:0] v);
    case (v)
      4'h0: hexdec = 7'h40;  4'h1: hexdec = 7'h79;
      4'h2: hexdec = 7'h24;  4'h3: hexdec = 7'h30;
      4'h4: hexdec = 7'h19;  4'h5: hexdec = 7'h12;
      4'h6: hexdec = 7'h02;  4'h7: hexdec = 7'h78;
      4'h8: hexdec = 7'h00;  4'h9: hexdec = 7'h10;
      4'hA: hexdec = 7'h08;  4'hB: hexdec = 7'h03;
      4'hC: hexdec = 7'h46;  4'hD: hexdec = 7'h21;
      4'hE: hexdec = 7'h06;  default: hexdec = 7'h0E;
    endcase
  endfunction

  always_comb begin
    slot_wrap = (slot_cnt == SLOT_LAST);
    boundary  = slot_wrap && (sel == SEL_LAST);
    cur_en    = 1'b0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_digit = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel == SEL_W'(k)) begin
        cur_en    = active_en[k];
        cur_dp    = active_dp[k];
        cur_blink = active_blink[k];
        cur_digit = active_digit[4*k +: 4];
      end
    end
    // Level 15 forces full duty so a slot length that is not a multiple of 16
    // never leaves a dark tail at maximum brightness.
    w_idx  = slot_cnt / SLOT_W'(WIN);
    pwm_on = (bright_q == 4'hF) || (w_idx <= SLOT_W'(bright_q));
    lit    = cur_en && pwm_on && !(cur_blink && blink_phase);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt     <= '0;
      sel          <= '0;
      frame_cnt    <= '0;
      blink_phase  <= 1'b0;
      bright_q     <= 4'h0;
      pending_q    <= 1'b0;
      pend_digit   <= '0;
      pend_en      <= '0;
      pend_dp      <= '0;
      pend_blink   <= '0;
      active_digit <= '0;
      active_en    <= '0;
      active_dp    <= '0;
      active_blink <= '0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_q      <= 1'b0;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
      if (slot_wrap)
        sel <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
      if (slot_cnt == '0)
        bright_q <= bus.brightness;

      if (boundary) begin
        if (frame_cnt == FRM_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      frame_q <= boundary;

      // A load landing on the boundary itself bypasses the shadow stage.
      if (boundary) begin
        if (bus.load) begin
          active_digit <= bus.digits_in;
          active_en    <= bus.en_in;
          active_dp    <= bus.dp_in;
          active_blink <= bus.blink_in;
        end else if (pending_q) begin
          active_digit <= pend_digit;
          active_en    <= pend_en;
          active_dp    <= pend_dp;
          active_blink <= pend_blink;
        end
        pending_q <= 1'b0;
      end else if (bus.load) begin
        pend_digit <= bus.digits_in;
        pend_en    <= bus.en_in;
        pend_dp    <= bus.dp_in;
        pend_blink <= bus.blink_in;
        pending_q  <= 1'b1;
      end

      for (int k = 0; k < NUM_DIGITS; k++)
        an_q[k] <= ~(lit && (sel == SEL_W'(k)));
      seg_q <= lit ? hexdec(cur_digit) : 7'h7F;
      dp_q  <= ~(lit && cur_dp);
    end
  end

  assign bus.an_n        = an_q;
  assign bus.seg_n       = seg_q;
  assign bus.dp_n        = dp_q;
  assign bus.frame_start = frame_q;
  assign bus.pending     = pending_q;
endmodule

// File: doc/mipsfpga_ahb_sevensegscan.md
Name: mipsfpga_ahb_sevensegscan

Overview:
- Parametrised multiplexed seven-segment scan driver, the successor to the fixed 8-digit timer for the Nexys4-DDR display.
- Generalised in digit count and scan rate.
- Adds, relative to the fixed timer: per-digit decimal point, per-digit blink, 16-level PWM brightness, and frame-synchronous double-buffered updates (no tearing).
- Sits behind the AHB GPIO/display register slave, which drives the load strobe and the shadow inputs.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (1..16).
- SLOT_CYCLES, 12500, clk cycles per digit slot; must be a multiple of 16 and at least 16.
- BLINK_FRAMES, 64, full scan frames per blink half-period (at least 1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  one-cycle strobe; captures digits_in/en_in/dp_in/blink_in into pending registers.
- digits_in  input  4*NUM_DIGITS  hex value per digit; digit k = bits [4k+3:4k].
- en_in  input  NUM_DIGITS  1 = digit enabled.
- dp_in  input  NUM_DIGITS  1 = decimal point lit.
- blink_in  input  NUM_DIGITS  1 = digit blinks.
- brightness  input  4  live duty level, 0 = 1/16, 15 = full.
- an_n  output  NUM_DIGITS  anode enables, active-low.
- seg_n  output  7  segments, active-low; bit0 = a … bit6 = g.
- dp_n  output  1  decimal point, active-low.
- frame_start  output  1  one-cycle pulse at each frame boundary.
- pending  output  1  1 while a loaded update awaits its frame boundary.

Behaviour:
- Reset (synchronous, active-high, wins over all other inputs):
  - slot_cnt, sel, frame_cnt, blink_phase, pending and all active/pending registers clear to 0 (all digits disabled).
  - an_n = all ones, seg_n = 7'h7F, dp_n = 1, frame_start = 0.
- Reset asserted mid-frame: the scan restarts at digit 0 on the first cycle after reset deasserts. Any pending update is discarded.
- Scan timing:
  - slot_cnt counts 0..SLOT_CYCLES-1 every clk and wraps.
  - On wrap, sel advances 0..NUM_DIGITS-1 and wraps to 0.
  - The frame boundary is the cycle where slot_cnt = SLOT_CYCLES-1 and sel = NUM_DIGITS-1.
- frame_start is registered and is high for the one cycle after the boundary cycle, i.e. coincident with sel = 0, slot_cnt = 0.
- Shadow/active registers:
  - load: pending regs <= inputs, pending <= 1.
  - A load while pending = 1 overwrites the pending regs (last load wins).
  - At the boundary cycle: if pending = 1, active <= pending regs and pending <= 0.
  - load on the boundary cycle: active <= inputs directly (bypass), pending stays 0.
- Brightness:
  - Sampled into bright_q when slot_cnt = 0, so the level is constant for the whole slot.
  - W = SLOT_CYCLES/16; window index w = slot_cnt / W.
  - pwm_on = (w <= bright_q).
- Blink:
  - frame_cnt counts boundaries 0..BLINK_FRAMES-1.
  - On wrap, blink_phase toggles (the toggle occurs on the boundary cycle).
- lit = active_en[sel] & pwm_on & ~(active_blink[sel] & blink_phase).
- Outputs, all registered with 1-cycle latency from the (sel, slot_cnt) state:
  - an_n: bit sel = ~lit, all other bits 1.
  - seg_n = lit ? hexdec(active_digit[sel]) : 7'h7F.
  - dp_n = ~(lit & active_dp[sel]).
- Hex decode, seg_n active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Never more than one an_n bit low.
- No glitch between digits: sel changes and outputs update on the same registered edge.
- brightness changes mid-slot take effect at the next slot.
- NUM_DIGITS = 1: sel is constant 0 and every slot wrap is a frame boundary.

Test Plan:
1. Reset, then parameters NUM_DIGITS=4, SLOT_CYCLES=32, BLINK_FRAMES=2, with no load.
   -> an_n = 4'hF, seg_n = 7'h7F, dp_n = 1 for all cycles; frame_start pulses every 128 cycles.
2. load with digits_in = 16'h3210, en_in = 4'hF, brightness = 15.
   -> pending = 1 until the boundary.
   -> In the next frame, an_n walks E,D,B,7, each for 32 cycles, with seg_n = 40,79,24,30 respectively.
3. brightness = 3, digit 0 enabled.
   -> In slot 0, an_n[0] = 0 for exactly 8 of 32 cycles (windows 0–3), then 1.
4. blink_in = 4'b0010, BLINK_FRAMES = 2.
   -> Digit 1 is lit for 2 frames and blank for 2 frames, repeating.
   -> Digits 0, 2 and 3 are lit every frame.
5. Load A mid-frame, load B before the boundary, then load C exactly on a boundary cycle.
   -> Active shows B after the first boundary.
   -> C is applied on the cycle after its load, with pending = 0 throughout.
6. Assert reset for 1 cycle mid-slot with sel = 2.
   -> Next cycle outputs are at reset values.
   -> After release, the scan resumes from sel = 0, slot_cnt = 0; all digits stay dark until a new load is applied.
